// File: rtl/response_tree_pkg.sv
// rtl/response_tree_pkg.sv - shared sizing helpers for the response fan-in tree
package response_tree_pkg;

   localparam int CNT_WIDTH = 16;

   // Tree depth, which is also the width of the slave id carried to the root.
   function automatic int tree_levels(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int level_nodes(input int n, input int lvl);
      return (n + (1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/response_tree_node.sv
// rtl/response_tree_node.sv - two-input priority fan-in node with optional output register
module response_tree_node
   import response_tree_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OPC_WIDTH  = 1,
   parameter int ID_WIDTH   = 4,
   parameter int SEL_BIT    = 0,
   parameter int REG        = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid0,
   input  logic [DATA_WIDTH-1:0] data0,
   input  logic [OPC_WIDTH-1:0]  opc0,
   input  logic [ID_WIDTH-1:0]   id0,
   input  logic                  valid1,
   input  logic [DATA_WIDTH-1:0] data1,
   input  logic [OPC_WIDTH-1:0]  opc1,
   input  logic [ID_WIDTH-1:0]   id1,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [OPC_WIDTH-1:0]  opc,
   output logic [ID_WIDTH-1:0]   id
);

   logic                  valid_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic [OPC_WIDTH-1:0]  opc_n;
   logic [ID_WIDTH-1:0]   id_n;

   // Input 0 has priority; payload is zeroed when neither side is valid.
   always_comb begin
      valid_n = valid0 | valid1;
      data_n  = '0;
      opc_n   = '0;
      id_n    = '0;
      if (valid0) begin
         data_n = data0;
         opc_n  = opc0;
         id_n   = id0;
      end else if (valid1) begin
         data_n        = data1;
         opc_n         = opc1;
         id_n          = id1;
         id_n[SEL_BIT] = 1'b1;
      end
   end

   if (REG != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            opc   <= '0;
            id    <= '0;
         end else begin
            valid <= valid_n;
            data  <= data_n;
            opc   <= opc_n;
            id    <= id_n;
         end
      end
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign valid = valid_n;
      assign data  = data_n;
      assign opc   = opc_n;
      assign id    = id_n;
   end

endmodule

// File: rtl/response_tree_pipe_pe.sv
// rtl/response_tree_pipe_pe.sv - pipelined priority response merge tree with collision flag and counter
module response_tree_pipe_pe
   import response_tree_pkg::*;
#(
   parameter int  N_SLAVE    = 16,
   parameter int  DATA_WIDTH = 32,
   parameter int  OPC_WIDTH  = 1,
   parameter int  REG_EVERY  = 2,
   localparam int ID_WIDTH   = tree_levels(N_SLAVE)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_SLAVE-1:0]                  data_r_valid_i,
   input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]  data_r_rdata_i,
   input  logic [N_SLAVE-1:0][OPC_WIDTH-1:0]   data_r_opc_i,
   output logic                                data_r_valid_o,
   output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
   output logic [OPC_WIDTH-1:0]                data_r_opc_o,
   output logic [ID_WIDTH-1:0]                 data_r_id_o,
   input  logic                                clr_i,
   output logic                                collision_o,
   output logic [CNT_WIDTH-1:0]                resp_cnt_o
);

   localparam int LEVELS = ID_WIDTH;
   localparam int REG_DIV = (REG_EVERY == 0) ? 1 : REG_EVERY;

   // Row k holds the outputs of tree level k; row 0 is the raw slave inputs.
   logic                  lvl_valid [LEVELS+1][N_SLAVE];
   logic [DATA_WIDTH-1:0] lvl_data  [LEVELS+1][N_SLAVE];
   logic [OPC_WIDTH-1:0]  lvl_opc   [LEVELS+1][N_SLAVE];
   logic [ID_WIDTH-1:0]   lvl_id    [LEVELS+1][N_SLAVE];

   genvar k, j;

   for (j = 0; j < N_SLAVE; j++) begin : g_leaf
      assign lvl_valid[0][j] = data_r_valid_i[j];
      assign lvl_data[0][j]  = data_r_rdata_i[j];
      assign lvl_opc[0][j]   = data_r_opc_i[j];
      assign lvl_id[0][j]    = '0;
   end

   for (k = 1; k <= LEVELS; k++) begin : g_level
      localparam int NODES    = level_nodes(N_SLAVE, k);
      localparam int PREV     = level_nodes(N_SLAVE, k - 1);
      localparam int REG_HERE = (REG_EVERY != 0 && (k % REG_DIV) == 0) ? 1 : 0;

      for (j = 0; j < N_SLAVE; j++) begin : g_node
         if (j < NODES && (2 * j + 1) < PREV) begin : g_pair
            response_tree_node #(
               .DATA_WIDTH (DATA_WIDTH),
               .OPC_WIDTH  (OPC_WIDTH),
               .ID_WIDTH   (ID_WIDTH),
               .SEL_BIT    (k - 1),
               .REG        (REG_HERE)
            ) u_node (
               .clk    (clk),
               .rst    (rst),
               .valid0 (lvl_valid[k-1][2*j]),
               .data0  (lvl_data[k-1][2*j]),
               .opc0   (lvl_opc[k-1][2*j]),
               .id0    (lvl_id[k-1][2*j]),
               .valid1 (lvl_valid[k-1][2*j+1]),
               .data1  (lvl_data[k-1][2*j+1]),
               .opc1   (lvl_opc[k-1][2*j+1]),
               .id1    (lvl_id[k-1][2*j+1]),
               .valid  (lvl_valid[k][j]),
               .data   (lvl_data[k][j]),
               .opc    (lvl_opc[k][j]),
               .id     (lvl_id[k][j])
            );
         end else if (j < NODES) begin : g_pass
            // Unpaired node: wire straight through, but keep the level's flop so latency stays uniform.
            if (REG_HERE != 0) begin : g_reg
               logic                  valid_q;
               logic [DATA_WIDTH-1:0] data_q;
               logic [OPC_WIDTH-1:0]  opc_q;
               logic [ID_WIDTH-1:0]   id_q;
               always_ff @(posedge clk or posedge rst) begin
                  if (rst) begin
                     valid_q <= 1'b0;
                     data_q  <= '0;
                     opc_q   <= '0;
                     id_q    <= '0;
                  end else begin
                     valid_q <= lvl_valid[k-1][2*j];
                     data_q  <= lvl_data[k-1][2*j];
                     opc_q   <= lvl_opc[k-1][2*j];
                     id_q    <= lvl_id[k-1][2*j];
                  end
               end
               assign lvl_valid[k][j] = valid_q;
               assign lvl_data[k][j]  = data_q;
               assign lvl_opc[k][j]   = opc_q;
               assign lvl_id[k][j]    = id_q;
            end else begin : g_wire
               assign lvl_valid[k][j] = lvl_valid[k-1][2*j];
               assign lvl_data[k][j]  = lvl_data[k-1][2*j];
               assign lvl_opc[k][j]   = lvl_opc[k-1][2*j];
               assign lvl_id[k][j]    = lvl_id[k-1][2*j];
            end
         end else begin : g_empty
            assign lvl_valid[k][j] = 1'b0;
            assign lvl_data[k][j]  = '0;
            assign lvl_opc[k][j]   = '0;
            assign lvl_id[k][j]    = '0;
         end
      end
   end

   assign data_r_valid_o = lvl_valid[LEVELS][0];
   assign data_r_rdata_o = lvl_data[LEVELS][0];
   assign data_r_opc_o   = lvl_opc[LEVELS][0];
   assign data_r_id_o    = lvl_id[LEVELS][0];

   // v & (v-1) clears the lowest set bit, so anything left means two or more valids.
   logic multi_valid;
   assign multi_valid = |(data_r_valid_i & (data_r_valid_i - N_SLAVE'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         collision_o <= 1'b0;
      end else if (clr_i) begin
         collision_o <= multi_valid;
      end else if (multi_valid) begin
         collision_o <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_cnt_o <= '0;
      end else if (clr_i) begin
         resp_cnt_o <= '0;
      end else if (data_r_valid_o) begin
         resp_cnt_o <= resp_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_response_tree_pipe_pe.sv
// tb/tb_response_tree_pipe_pe.sv - self-checking bench for response_tree_pipe_pe
module tb_response_tree_pipe_pe;

   localparam int N   = 16;
   localparam int DW  = 32;
   localparam int OW  = 1;
   localparam int IW  = 4;
   localparam int LAT = 2;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] data;
      logic [OW-1:0] opc;
      logic [IW-1:0] id;
   } resp_t;

   logic                 clk, rst, clr;
   logic [N-1:0]         valid_in;
   logic [N-1:0][DW-1:0] rdata_in;
   logic [N-1:0][OW-1:0] opc_in;
   logic                 valid_out;
   logic [DW-1:0]        rdata_out;
   logic [OW-1:0]        opc_out;
   logic [IW-1:0]        id_out;
   logic                 collision;
   logic [15:0]          resp_cnt;

   logic [4:0]           valid5;
   logic [4:0][DW-1:0]   rdata5;
   logic [4:0][OW-1:0]   opc5;
   logic                 valid5_out;
   logic [DW-1:0]        rdata5_out;
   logic [OW-1:0]        opc5_out;
   logic [2:0]           id5_out;
   logic                 unused_col5;
   logic [15:0]          unused_cnt5;

   int n_cmp = 0;
   int n_bad = 0;

   response_tree_pipe_pe #(.N_SLAVE(N), .DATA_WIDTH(DW), .OPC_WIDTH(OW), .REG_EVERY(2)) dut (
      .clk(clk), .rst(rst),
      .data_r_valid_i(valid_in), .data_r_rdata_i(rdata_in), .data_r_opc_i(opc_in),
      .data_r_valid_o(valid_out), .data_r_rdata_o(rdata_out), .data_r_opc_o(opc_out),
      .data_r_id_o(id_out), .clr_i(clr), .collision_o(collision), .resp_cnt_o(resp_cnt)
   );

   response_tree_pipe_pe #(.N_SLAVE(5), .DATA_WIDTH(DW), .OPC_WIDTH(OW), .REG_EVERY(0)) dut5 (
      .clk(clk), .rst(rst),
      .data_r_valid_i(valid5), .data_r_rdata_i(rdata5), .data_r_opc_i(opc5),
      .data_r_valid_o(valid5_out), .data_r_rdata_o(rdata5_out), .data_r_opc_o(opc5_out),
      .data_r_id_o(id5_out), .clr_i(clr), .collision_o(unused_col5), .resp_cnt_o(unused_cnt5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the lowest-index valid slave wins, otherwise an all-zero response.
   function automatic resp_t pick(input logic [N-1:0] v, input logic [N-1:0][DW-1:0] d,
                                  input logic [N-1:0][OW-1:0] o);
      resp_t r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) begin
            r.valid = 1'b1;
            r.data  = d[i];
            r.opc   = o[i];
            r.id    = IW'(i);
         end
      end
      return r;
   endfunction

   resp_t       exp_q [LAT];
   logic [15:0] exp_cnt;
   logic        exp_col;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q[0] <= '0;
         exp_q[1] <= '0;
         exp_cnt  <= '0;
         exp_col  <= 1'b0;
      end else begin
         exp_q[0] <= pick(valid_in, rdata_in, opc_in);
         exp_q[1] <= exp_q[0];
         exp_cnt  <= clr ? 16'd0 : (exp_q[LAT-1].valid ? exp_cnt + 16'd1 : exp_cnt);
         exp_col  <= ($countones(valid_in) >= 2) || (exp_col && !clr);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("model_valid", 64'(valid_out), 64'(exp_q[LAT-1].valid));
         check("model_rdata", 64'(rdata_out), 64'(exp_q[LAT-1].data));
         check("model_opc", 64'(opc_out), 64'(exp_q[LAT-1].opc));
         check("model_id", 64'(id_out), 64'(exp_q[LAT-1].id));
         check("model_cnt", 64'(resp_cnt), 64'(exp_cnt));
         check("model_collision", 64'(collision), 64'(exp_col));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      clr = 1'b0;
      valid_in = '0;
      valid5 = '0;
      for (int i = 0; i < N; i++) begin
         rdata_in[i] = 32'h5A00_0000 | 32'(i);
         opc_in[i]   = OW'(i & 1);
      end
      for (int i = 0; i < 5; i++) begin
         rdata5[i] = 32'h7700_0000 | 32'(i);
         opc5[i]   = '0;
      end
      #1 rst = 1'b1;
      #2;
      check("reset_valid", 64'(valid_out), 64'd0);
      check("reset_rdata", 64'(rdata_out), 64'd0);
      check("reset_id", 64'(id_out), 64'd0);
      check("reset_cnt", 64'(resp_cnt), 64'd0);
      check("reset_collision", 64'(collision), 64'd0);
      #10 rst = 1'b0;
      step();

      // Single response from slave 5, two-cycle latency
      rdata_in[5] = 32'hDEAD_BEEF;
      opc_in[5]   = 1'b1;
      valid_in    = 16'h0020;
      step();
      valid_in = '0;
      step();
      check("lat_valid", 64'(valid_out), 64'd1);
      check("lat_rdata", 64'(rdata_out), 64'hDEAD_BEEF);
      check("lat_opc", 64'(opc_out), 64'd1);
      check("lat_id", 64'(id_out), 64'd5);
      step();
      check("lat_idle_valid", 64'(valid_out), 64'd0);
      check("lat_idle_rdata", 64'(rdata_out), 64'd0);

      // Collision: slaves 3 and 9
      rdata_in[3] = 32'h3333_0003;
      rdata_in[9] = 32'h9999_0009;
      valid_in    = 16'h0208;
      step();
      valid_in = '0;
      check("col_next_cycle", 64'(collision), 64'd1);
      step();
      check("col_rdata", 64'(rdata_out), 64'h3333_0003);
      check("col_id", 64'(id_out), 64'd3);
      repeat (3) step();
      check("col_sticky", 64'(collision), 64'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("col_cleared", 64'(collision), 64'd0);
      valid_in = 16'h0003;
      clr      = 1'b1;
      step();
      valid_in = '0;
      clr      = 1'b0;
      check("col_clr_and_new", 64'(collision), 64'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("col_cleared2", 64'(collision), 64'd0);
      repeat (3) step();

      // Back-to-back, one slave per cycle
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < N; i++) begin
         valid_in = N'(1) << i;
         step();
      end
      valid_in = '0;
      repeat (3) step();
      check("b2b_cnt", 64'(resp_cnt), 64'd16);

      // Counter wrap
      clr = 1'b1;
      step();
      clr = 1'b0;
      valid_in = 16'h0001;
      repeat (65535) step();
      valid_in = '0;
      repeat (3) step();
      check("cnt_preset", 64'(resp_cnt), 64'hFFFF);
      valid_in = 16'h0001;
      step();
      valid_in = '0;
      repeat (3) step();
      check("cnt_wrap", 64'(resp_cnt), 64'd0);
      valid_in = 16'h0010;
      step();
      valid_in = '0;
      step();
      check("clr_valid_out", 64'(valid_out), 64'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_with_valid", 64'(resp_cnt), 64'd0);
      repeat (3) step();

      // Reset with two responses in flight
      valid_in = 16'h0004;
      step();
      valid_in = 16'h0080;
      step();
      valid_in = '0;
      check("inflight_valid", 64'(valid_out), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(valid_out), 64'd0);
      check("rst_async_rdata", 64'(rdata_out), 64'd0);
      check("rst_async_id", 64'(id_out), 64'd0);
      check("rst_async_cnt", 64'(resp_cnt), 64'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_valid", 64'(valid_out), 64'd0);
      end
      check("post_rst_cnt", 64'(resp_cnt), 64'd0);

      // Five slaves, fully combinational
      opc5[4]   = 1'b1;
      rdata5[4] = 32'h1234_5678;
      valid5    = 5'b10000;
      #1;
      check("n5_valid", 64'(valid5_out), 64'd1);
      check("n5_rdata", 64'(rdata5_out), 64'h1234_5678);
      check("n5_opc", 64'(opc5_out), 64'd1);
      check("n5_id", 64'(id5_out), 64'd4);
      valid5 = 5'b00000;
      #1;
      check("n5_none_valid", 64'(valid5_out), 64'd0);
      check("n5_none_rdata", 64'(rdata5_out), 64'd0);
      check("n5_none_id", 64'(id5_out), 64'd0);
      valid5 = 5'b10010;
      #1;
      check("n5_prio_rdata", 64'(rdata5_out), 64'h7700_0001);
      check("n5_prio_id", 64'(id5_out), 64'd1);
      valid5 = 5'b01000;
      #1;
      check("n5_id3", 64'(id5_out), 64'd3);
      valid5 = '0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
